// File: rtl/tx_serial_param_if.sv
// Handshake and line signals between the application FSM and the serial transmitter.
interface tx_serial_param_if #(
    parameter int N_DADOS = 7
);
    logic               partida;
    logic [N_DADOS-1:0] dados;
    logic               saida_serial;
    logic               pronto;
    logic               ocupado;
    logic [3:0]         db_estado;

    modport master (
        output partida,
        output dados,
        input  saida_serial,
        input  pronto,
        input  ocupado,
        input  db_estado
    );

    modport slave (
        input  partida,
        input  dados,
        output saida_serial,
        output pronto,
        output ocupado,
        output db_estado
    );
endinterface

// File: rtl/tx_serial_param.sv
// Parametrised UART-style transmitter: one frame (start, data LSB first, optional parity,
// stop bits) per rising edge of partida, with a one-cycle pronto at end of frame.
module tx_serial_param #(
    parameter int N_DADOS  = 7,
    parameter int PARIDADE = 0,
    parameter int N_STOP   = 2,
    parameter int DIV      = 434,
    parameter int W_DIV    = 9
) (
    input logic              clock,
    input logic              reset,
    tx_serial_param_if.slave bus
);
    typedef enum logic [3:0] {
        ST_OCIOSO   = 4'd0,
        ST_INICIO   = 4'd1,
        ST_DADOS    = 4'd2,
        ST_PARIDADE = 4'd3,
        ST_PARADA   = 4'd4,
        ST_FIM      = 4'd5
    } estado_t;

    // Frame formats outside the supported set must never reach silicon.
    generate
        if ((PARIDADE < 32'sd0) || (PARIDADE > 32'sd2) ||
            (N_STOP < 32'sd1) || (N_STOP > 32'sd2) ||
            (N_DADOS < 32'sd5) || (N_DADOS > 32'sd9) ||
            (DIV < 32'sd1) || ((DIV - 32'sd1) >= (32'sd1 <<< W_DIV))) begin : g_cfg_error
            $error("tx_serial_param: illegal frame configuration");
        end
    endgenerate

    function automatic logic parity_bit(input logic [N_DADOS-1:0] word);
        if (PARIDADE == 32'sd2) begin
            return ~^word;
        end else begin
            return ^word;
        end
    endfunction

    estado_t            state_r, state_s;
    logic [W_DIV-1:0]   tick_cnt_r, tick_cnt_s;
    logic [3:0]         bit_cnt_r, bit_cnt_s;
    logic [N_DADOS-1:0] shift_r, shift_s;
    logic               par_r, par_s;
    logic               partida_d_r;
    logic               saida_r, pronto_r, ocupado_r;
    logic               start_s, tick_s, last_data_s, last_stop_s, line_s;

    assign start_s     = bus.partida & ~partida_d_r;
    assign tick_s      = (tick_cnt_r == W_DIV'(DIV - 1));
    assign last_data_s = (bit_cnt_r == 4'(N_DADOS - 1));
    assign last_stop_s = (bit_cnt_r == 4'(N_STOP - 1));

    // Next-state, counters and the line value that the next state will present.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        par_s      = par_r;
        bit_cnt_s  = bit_cnt_r;
        tick_cnt_s = tick_s ? {W_DIV{1'b0}} : tick_cnt_r + W_DIV'(1);
        case (state_r)
            ST_OCIOSO: begin
                tick_cnt_s = {W_DIV{1'b0}};
                bit_cnt_s  = 4'd0;
                if (start_s) begin
                    state_s = ST_INICIO;
                    shift_s = bus.dados;
                    par_s   = parity_bit(bus.dados);
                end else begin
                    state_s = ST_OCIOSO;
                end
            end
            ST_INICIO: begin
                if (tick_s) begin
                    state_s = ST_DADOS;
                end else begin
                    state_s = ST_INICIO;
                end
            end
            ST_DADOS: begin
                if (tick_s) begin
                    shift_s = shift_r >> 1;
                    if (last_data_s) begin
                        bit_cnt_s = 4'd0;
                        state_s   = (PARIDADE != 32'sd0) ? ST_PARIDADE : ST_PARADA;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                end else begin
                    state_s = ST_DADOS;
                end
            end
            ST_PARIDADE: begin
                if (tick_s) begin
                    state_s = ST_PARADA;
                end else begin
                    state_s = ST_PARIDADE;
                end
            end
            ST_PARADA: begin
                if (tick_s) begin
                    if (last_stop_s) begin
                        bit_cnt_s = 4'd0;
                        state_s   = ST_FIM;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                end else begin
                    state_s = ST_PARADA;
                end
            end
            ST_FIM: begin
                tick_cnt_s = {W_DIV{1'b0}};
                bit_cnt_s  = 4'd0;
                state_s    = ST_OCIOSO;
            end
            default: begin
                tick_cnt_s = {W_DIV{1'b0}};
                bit_cnt_s  = 4'd0;
                state_s    = ST_OCIOSO;
            end
        endcase

        // Line is registered from the next state so the start bit appears one cycle after acceptance.
        case (state_s)
            ST_INICIO:   line_s = 1'b0;
            ST_DADOS:    line_s = shift_s[0];
            ST_PARIDADE: line_s = par_s;
            default:     line_s = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_OCIOSO;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers and registered outputs; reset aborts any frame without pronto.
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt_r  <= {W_DIV{1'b0}};
            bit_cnt_r   <= 4'd0;
            shift_r     <= {N_DADOS{1'b0}};
            par_r       <= 1'b0;
            partida_d_r <= 1'b0;
            saida_r     <= 1'b1;
            pronto_r    <= 1'b0;
            ocupado_r   <= 1'b0;
        end else begin
            tick_cnt_r  <= tick_cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            par_r       <= par_s;
            partida_d_r <= bus.partida;
            saida_r     <= line_s;
            pronto_r    <= (state_s == ST_FIM);
            ocupado_r   <= (state_s != ST_OCIOSO);
        end
    end

    assign bus.saida_serial = saida_r;
    assign bus.pronto       = pronto_r;
    assign bus.ocupado      = ocupado_r;
    assign bus.db_estado    = state_r;
endmodule
